// File: rtl/nunchuck_pkg.sv
// Shared definitions for the nunchuck input conditioning blocks.
//   DIR_*         : bit index of each direction inside a channel's 4-bit group
//   STICK_CENTER  : raw joystick value at rest
//   dir_state_t   : per-direction auto-repeat FSM state
//   stick_offset  : signed offset of a raw stick byte from centre
package nunchuck_pkg;

    localparam int unsigned DIR_RIGHT    = 0;
    localparam int unsigned DIR_LEFT     = 1;
    localparam int unsigned DIR_UP       = 2;
    localparam int unsigned DIR_DOWN     = 3;
    localparam int unsigned STICK_CENTER = 128;

    typedef enum logic {
        IDLE,
        HELD
    } dir_state_t;

    // 10 bits so that negating the result can never overflow.
    function automatic logic signed [9:0] stick_offset(input logic [7:0] stick);
        logic signed [9:0] off;
        off = $signed({2'b00, stick}) - $signed(10'(STICK_CENTER));
        return off;
    endfunction

endpackage

// File: rtl/nunchuck_chan_cond.sv
// One nunchuck channel: debounces Z and C, turns the stick into four
// hysteretic direction flags with auto-repeat. All state advances on tick.
//   clkin, rst          : clock, synchronous active-high reset
//   tick                : sample strobe from the hub
//   stick_x, stick_y    : registered raw stick bytes
//   z_in, c_in          : registered raw buttons (1 = pressed)
//   z_level, c_level    : debounced button levels
//   z_press, c_press    : one-cycle pulse on debounced 0->1
//   dir_level           : {down, up, left, right} flags
//   dir_pulse           : one-cycle pulse on assertion and on each repeat
module nunchuck_chan_cond
    import nunchuck_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned DEADZONE       = 32,
    parameter int unsigned HYST           = 8,
    parameter int unsigned REPEAT_DELAY   = 25,
    parameter int unsigned REPEAT_RATE    = 6
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] stick_x,
    input  logic [7:0] stick_y,
    input  logic       z_in,
    input  logic       c_in,
    output logic       z_level,
    output logic       c_level,
    output logic       z_press,
    output logic       c_press,
    output logic [3:0] dir_level,
    output logic [3:0] dir_pulse
);

    localparam int unsigned CW      = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);
    localparam logic signed [9:0] ON_TH  = 10'(DEADZONE);
    localparam logic signed [9:0] OFF_TH = 10'(DEADZONE - HYST);

    // ---------------- button debounce (index 0 = Z, 1 = C) ----------------
    logic [1:0]    btn;
    logic [1:0]    lvl;
    logic [1:0]    press;
    logic [CW-1:0] db_cnt [2];

    assign btn = {c_in, z_in};

    always_ff @(posedge clkin) begin
        if (rst) begin
            lvl   <= '0;
            press <= '0;
            for (int unsigned b = 0; b < 2; b++) db_cnt[b] <= '0;
        end else begin
            press <= '0;
            if (tick) begin
                for (int unsigned b = 0; b < 2; b++) begin
                    if (btn[b] == lvl[b]) begin
                        db_cnt[b] <= '0;
                    end else if (db_cnt[b] + 1'b1 == CW'(DEBOUNCE_TICKS)) begin
                        lvl[b]    <= ~lvl[b];
                        db_cnt[b] <= '0;
                        press[b]  <= ~lvl[b];
                    end else begin
                        db_cnt[b] <= db_cnt[b] + 1'b1;
                    end
                end
            end
        end
    end

    assign z_level = lvl[0];
    assign c_level = lvl[1];
    assign z_press = press[0];
    assign c_press = press[1];

    // ---------------- direction FSMs ----------------
    logic signed [9:0] off_x, off_y;
    logic signed [9:0] dir_off [4];
    dir_state_t        state [4];
    dir_state_t        state_nxt [4];
    logic [RW-1:0]     rpt [4];
    logic [RW-1:0]     rpt_nxt [4];
    logic [3:0]        pulse_q, pulse_nxt;

    assign off_x = stick_offset(stick_x);
    assign off_y = stick_offset(stick_y);

    always_comb begin
        dir_off[DIR_RIGHT] = off_x;
        dir_off[DIR_LEFT]  = -off_x;
        dir_off[DIR_UP]    = off_y;
        dir_off[DIR_DOWN]  = -off_y;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            pulse_q <= '0;
            for (int unsigned d = 0; d < 4; d++) begin
                state[d] <= IDLE;
                rpt[d]   <= '0;
            end
        end else begin
            pulse_q <= pulse_nxt;
            for (int unsigned d = 0; d < 4; d++) begin
                state[d] <= state_nxt[d];
                rpt[d]   <= rpt_nxt[d];
            end
        end
    end

    // Release is checked before the repeat countdown so leaving HELD never pulses.
    always_comb begin
        pulse_nxt = '0;
        for (int unsigned d = 0; d < 4; d++) begin
            state_nxt[d] = state[d];
            rpt_nxt[d]   = rpt[d];
            if (tick) begin
                case (state[d])
                    IDLE: begin
                        if (dir_off[d] > ON_TH) begin
                            state_nxt[d] = HELD;
                            rpt_nxt[d]   = RW'(REPEAT_DELAY);
                            pulse_nxt[d] = 1'b1;
                        end
                    end
                    HELD: begin
                        if (dir_off[d] <= OFF_TH) begin
                            state_nxt[d] = IDLE;
                            rpt_nxt[d]   = '0;
                        end else if (rpt[d] == RW'(1)) begin
                            rpt_nxt[d]   = RW'(REPEAT_RATE);
                            pulse_nxt[d] = 1'b1;
                        end else begin
                            rpt_nxt[d]   = rpt[d] - 1'b1;
                        end
                    end
                    default: state_nxt[d] = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int unsigned d = 0; d < 4; d++) dir_level[d] = (state[d] == HELD);
        dir_pulse = pulse_q;
    end

endmodule

// File: rtl/nunchuck_input_hub.sv
// N-channel nunchuck input conditioner: registers raw inputs, generates the
// shared sample tick, instantiates one conditioner per channel and drives LEDs.
//   clkin, rst            : clock, synchronous active-high reset
//   stick_x, stick_y      : raw sticks, channel i at [8i+7:8i]
//   z_raw, c_raw          : raw buttons per channel
//   z_level, c_level      : debounced levels
//   z_press, c_press      : press pulses
//   dir_level, dir_pulse  : direction flags / pulses, channel i at [4i+3:4i]
//   leds                  : leds[i] = z_level[i] for i < NUM_CH, others 1
module nunchuck_input_hub
    import nunchuck_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned SAMPLE_DIV     = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned DEADZONE       = 32,
    parameter int unsigned HYST           = 8,
    parameter int unsigned REPEAT_DELAY   = 25,
    parameter int unsigned REPEAT_RATE    = 6
) (
    input  logic                  clkin,
    input  logic                  rst,
    input  logic [NUM_CH*8-1:0]   stick_x,
    input  logic [NUM_CH*8-1:0]   stick_y,
    input  logic [NUM_CH-1:0]     z_raw,
    input  logic [NUM_CH-1:0]     c_raw,
    output logic [NUM_CH-1:0]     z_level,
    output logic [NUM_CH-1:0]     c_level,
    output logic [NUM_CH-1:0]     z_press,
    output logic [NUM_CH-1:0]     c_press,
    output logic [NUM_CH*4-1:0]   dir_level,
    output logic [NUM_CH*4-1:0]   dir_pulse,
    output logic [9:0]            leds
);

    localparam int unsigned TW = $clog2(SAMPLE_DIV);

    logic [TW-1:0]          tick_cnt;
    logic                   tick;
    logic [NUM_CH*8-1:0]    x_q, y_q;
    logic [NUM_CH-1:0]      z_q, c_q;
    logic [9:0]             led_next;

    assign tick = (tick_cnt == TW'(SAMPLE_DIV - 1));

    always_ff @(posedge clkin) begin
        if (rst) begin
            tick_cnt <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            c_q      <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            x_q      <= stick_x;
            y_q      <= stick_y;
            z_q      <= z_raw;
            c_q      <= c_raw;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        nunchuck_chan_cond #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .DEADZONE       (DEADZONE),
            .HYST           (HYST),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_chan (
            .clkin     (clkin),
            .rst       (rst),
            .tick      (tick),
            .stick_x   (x_q[8*ch +: 8]),
            .stick_y   (y_q[8*ch +: 8]),
            .z_in      (z_q[ch]),
            .c_in      (c_q[ch]),
            .z_level   (z_level[ch]),
            .c_level   (c_level[ch]),
            .z_press   (z_press[ch]),
            .c_press   (c_press[ch]),
            .dir_level (dir_level[4*ch +: 4]),
            .dir_pulse (dir_pulse[4*ch +: 4])
        );
    end

    always_comb begin
        led_next               = '1;
        led_next[NUM_CH-1:0]   = z_level;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            leds             <= '1;
            leds[NUM_CH-1:0] <= '0;
        end else begin
            leds <= led_next;
        end
    end

endmodule

// File: tb/tb_nunchuck_input_hub.sv
module tb_nunchuck_input_hub;

    logic        clkin;
    logic        rst;
    logic [15:0] stick_x, stick_y;
    logic [1:0]  z_raw, c_raw;
    logic [1:0]  z_level, c_level, z_press, c_press;
    logic [7:0]  dir_level, dir_pulse;
    logic [9:0]  leds;

    int n_checks = 0;
    int n_errors = 0;
    int phase    = 0;
    logic last_tick;

    nunchuck_input_hub #(
        .NUM_CH         (2),
        .SAMPLE_DIV     (4),
        .DEBOUNCE_TICKS (3),
        .DEADZONE       (32),
        .HYST           (8),
        .REPEAT_DELAY   (3),
        .REPEAT_RATE    (2)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .stick_x   (stick_x),
        .stick_y   (stick_y),
        .z_raw     (z_raw),
        .c_raw     (c_raw),
        .z_level   (z_level),
        .c_level   (c_level),
        .z_press   (z_press),
        .c_press   (c_press),
        .dir_level (dir_level),
        .dir_pulse (dir_pulse),
        .leds      (leds)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; last_tick says whether the edge just taken was a sample tick.
    task automatic cyc();
        logic r;
        logic t;
        r = rst;
        t = (phase == 3) && !r;
        @(posedge clkin);
        if (r) phase = 0;
        else   phase = (phase == 3) ? 0 : phase + 1;
        last_tick = t;
        #1;
    endtask

    // Advance to just after the next tick edge (outputs then reflect that tick).
    task automatic next_tick();
        int guard;
        guard = 0;
        do begin
            cyc();
            guard++;
        end while (!last_tick && guard < 8);
        if (!last_tick) check("tick_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        stick_x = 16'h8080;
        stick_y = 16'h8080;
        z_raw   = 2'b01;
        c_raw   = 2'b10;

        // Reset
        repeat (3) cyc();
        check("rst_z_level", 32'(z_level), 32'h0);
        check("rst_c_level", 32'(c_level), 32'h0);
        check("rst_press", 32'({z_press, c_press}), 32'h0);
        check("rst_dir", 32'({dir_level, dir_pulse}), 32'h0);
        check("rst_leds", 32'(leds), 32'h3FC);

        // Z debounce on ch0
        rst   = 1'b0;
        c_raw = 2'b00;
        z_raw = 2'b01;
        next_tick(); check("z_t1_level", 32'(z_level), 32'h0);
        next_tick(); check("z_t2_level", 32'(z_level), 32'h0);
        next_tick();
        check("z_t3_level", 32'(z_level), 32'h1);
        check("z_t3_press", 32'(z_press), 32'h1);
        check("z_t3_leds", 32'(leds), 32'h3FC);
        check("c_level_quiet", 32'(c_level), 32'h0);
        cyc();
        check("z_press_width", 32'(z_press), 32'h0);
        check("z_leds", 32'(leds), 32'h3FD);

        // Bounce: 0,1,0,0,1 never reaches three consecutive differing ticks
        z_raw = 2'b00; next_tick(); check("bounce_a", 32'(z_level), 32'h1);
        z_raw = 2'b01; next_tick(); check("bounce_b", 32'(z_level), 32'h1);
        z_raw = 2'b00; next_tick();
        next_tick(); check("bounce_c", 32'(z_level), 32'h1);
        z_raw = 2'b01; next_tick(); check("bounce_d", 32'(z_level), 32'h1);

        // Release: level falls after 3 ticks with no pulse
        z_raw = 2'b00;
        next_tick(); next_tick(); check("rel_t2", 32'(z_level), 32'h1);
        next_tick();
        check("rel_level", 32'(z_level), 32'h0);
        check("rel_no_press", 32'(z_press), 32'h0);
        cyc();
        check("rel_leds", 32'(leds), 32'h3FC);

        // Right held: pulse on entry, then at +3, +5, +7, +9
        stick_x = 16'h80C8;
        next_tick();
        check("right_level", 32'(dir_level), 32'h01);
        check("right_pulse", 32'(dir_pulse), 32'h01);
        cyc();
        check("right_pulse_width", 32'(dir_pulse), 32'h00);
        for (int k = 2; k <= 10; k++) begin
            next_tick();
            check($sformatf("rpt_k%0d", k), 32'(dir_pulse),
                  (k == 4 || k == 6 || k == 8 || k == 10) ? 32'h01 : 32'h00);
        end
        // Offset +28 is inside the hysteresis band: stays held
        stick_x = 16'h809C;
        next_tick();
        check("band_level", 32'(dir_level), 32'h01);
        check("band_pulse", 32'(dir_pulse), 32'h00);
        // Offset -28: right releases, left stays below deadzone, no pulse
        stick_x = 16'h8064;
        next_tick();
        check("neg28_level", 32'(dir_level), 32'h00);
        check("neg28_pulse", 32'(dir_pulse), 32'h00);
        stick_x = 16'h8080;
        next_tick();
        check("center_level", 32'(dir_level), 32'h00);

        // ch1 down (offset -38), ch0 untouched
        stick_y = 16'h5A80;
        next_tick();
        check("ch1_down_level", 32'(dir_level), 32'h80);
        check("ch1_down_pulse", 32'(dir_pulse), 32'h80);
        check("ch1_ch0_btn", 32'({z_level, c_level}), 32'h0);
        cyc();
        check("ch1_pulse_width", 32'(dir_pulse), 32'h00);
        stick_y = 16'h8080;
        next_tick();
        check("ch1_release", 32'(dir_level), 32'h00);

        // Reset during repeat countdown
        stick_x = 16'h80C8;
        next_tick();
        check("pre_rst_pulse", 32'(dir_pulse), 32'h01);
        next_tick();
        check("pre_rst_count", 32'(dir_pulse), 32'h00);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("mid_rst_%0d", i), 32'({dir_level, dir_pulse}), 32'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("post_rst_%0d", i), 32'(dir_pulse), 32'h00);
        end
        next_tick();
        check("post_rst_pulse", 32'(dir_pulse), 32'h01);
        check("post_rst_level", 32'(dir_level), 32'h01);
        stick_x = 16'h8080;
        next_tick();
        check("post_rst_release", 32'(dir_level), 32'h00);

        // All four buttons together
        z_raw = 2'b11;
        c_raw = 2'b11;
        next_tick(); check("all_t1", 32'({z_press, c_press}), 32'h0);
        next_tick(); check("all_t2", 32'({z_level, c_level}), 32'h0);
        next_tick();
        check("all_press", 32'({z_press, c_press}), 32'hF);
        check("all_level", 32'({z_level, c_level}), 32'hF);
        cyc();
        check("all_press_width", 32'({z_press, c_press}), 32'h0);
        check("all_leds", 32'(leds), 32'h3FF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
